// File: rtl/dac_spi_readback_if.sv
// Read-request and SPI bus bundle for the DAC60508MC read engine.
// master: engine side (rd_* status, SPI pins, bus_req); slave: requester/mux/DAC side.
interface dac_spi_readback_if;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        busy;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_err;
  logic        bus_req;
  logic        bus_gnt;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  rd_req, rd_addr, bus_gnt, MISO,
    output busy, rd_valid, rd_data, rd_err,
    output bus_req, CS, SCLK, MOSI
  );

  modport slave (
    output rd_req, rd_addr, bus_gnt, MISO,
    input  busy, rd_valid, rd_data, rd_err,
    input  bus_req, CS, SCLK, MOSI
  );
endinterface

// File: rtl/dac_spi_readback.sv
// Two-frame SPI register read engine (read command, then NOP response) for the DAC60508MC.
// Ports: clk, rst_n (async low), bus (dac_spi_readback_if.master: rd_*, bus_req/gnt, CS/SCLK/MOSI/MISO).
module dac_spi_readback #(
  parameter int HALF_DIV = 4,
  parameter int CS_GAP   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dac_spi_readback_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int GW = $clog2(CS_GAP);
  localparam logic [7:0]    PH_LAST  = 8'(HALF_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [4:0]    BIT_LAST = 5'd23;

  logic [2:0]    state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    ph_q, ph_d;
  logic          lo_q, lo_d;
  logic [4:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  // The first of the 24 response bits never reaches an output,
  // so only the trailing 23 are kept.
  logic [22:0]   shift_q, shift_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [15:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [23:0]   cmd_word;
  logic          frame_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ph_d     = ph_q;
    lo_d     = lo_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shift_d  = shift_q;
    data_d   = data_q;
    err_d    = err_q;
    cmd_word = {1'b1, 3'b000, addr_q, 16'h0000};

    unique case (state_q)
      S_IDLE: begin
        if (bus.rd_req) begin
          state_d = S_REQ;
          addr_d  = bus.rd_addr;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          state_d = S_CMD;
          ph_d    = '0;
          lo_d    = 1'b0;
          bit_d   = '0;
        end
      end
      S_CMD, S_RESP: begin
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + 8'd1;
        end else if (!lo_q) begin
          // High phase over: SCLK falls next, MISO taken on this edge.
          ph_d = '0;
          lo_d = 1'b1;
          if (state_q == S_RESP) shift_d = {shift_q[21:0], bus.MISO};
        end else if (bit_q != BIT_LAST) begin
          ph_d  = '0;
          lo_d  = 1'b0;
          bit_d = bit_q + 5'd1;
        end else begin
          ph_d  = '0;
          lo_d  = 1'b0;
          bit_d = '0;
          gap_d = '0;
          if (state_q == S_CMD) begin
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
            data_d  = shift_q[15:0];
            err_d   = (shift_q[19:16] != addr_q);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_RESP;
          ph_d    = '0;
          lo_d    = 1'b0;
          bit_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next-state view so they change cleanly.
    frame_d = (state_d == S_CMD) || (state_d == S_RESP);
    cs_d    = !frame_d;
    sclk_d  = frame_d ? !lo_d : 1'b1;
    mosi_d  = (state_d == S_CMD) ? cmd_word[BIT_LAST - bit_d] : 1'b0;
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ph_q    <= '0;
      lo_q    <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      lo_q    <= lo_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.CS       = cs_q;
  assign bus.SCLK     = sclk_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.bus_req  = busy_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_data  = data_q;
  assign bus.rd_err   = err_q;

endmodule

// File: doc/dac_spi_readback.md
Name: dac_spi_readback

Overview:
- SPI read engine for the DAC60508MC. Verifies register contents such as CONFIG, GAIN and the DAC codes after the write driver has sent them.
- Runs a two-frame read: a read-command frame, then a NOP frame during which the DAC shifts the addressed register out on SDO.
- Shares CS/SCLK/MOSI with the write driver through a request/grant handshake with the bus mux. Clocked by the 200 MHz core clock.

Parameters:
- HALF_DIV, 4, clk cycles per SCLK half-period (4 gives 25 MHz SCLK at 200 MHz); legal range 2..255.
- CS_GAP, 8, clk cycles CS is held high between the command frame and the response frame; minimum 2.

Ports:
- clk  in  1  core clock, 200 MHz
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  start-read strobe; sampled only in IDLE
- rd_addr  in  4  register address; latched when rd_req is accepted
- busy  out  1  high from acceptance until the cycle after rd_valid
- rd_valid  out  1  one-cycle completion pulse
- rd_data  out  16  captured register data; held until the next completion
- rd_err  out  1  echoed address mismatch; valid with rd_valid, held like rd_data
- bus_req  out  1  SPI bus request to the mux
- bus_gnt  in  1  SPI bus grant from the mux
- CS  out  1  DAC chip select, active low
- SCLK  out  1  SPI clock, idles high
- MOSI  out  1  SPI data to the DAC
- MISO  in  1  SDO from the DAC, already synchronised by the mux

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - CS=1, SCLK=1, MOSI=0, busy=0, rd_valid=0, rd_data=0, rd_err=0, bus_req=0; state IDLE.
  - No partial frame resumes after reset.
- States: IDLE -> REQ -> CMD -> GAP -> RESP -> DONE -> IDLE.
- IDLE:
  - rd_req=1 latches rd_addr; next state REQ; busy=1 and bus_req=1 from the next cycle.
- REQ:
  - Waits indefinitely for bus_gnt=1.
  - On the first cycle bus_gnt=1 is seen, CS drops the following cycle and CMD begins.
- CMD frame: 24 bits, MSB first. Word = {1'b1, 3'b000, addr, 16'h0000}.
- Bit timing (CMD and RESP):
  - Each bit is SCLK high for HALF_DIV cycles, then low for HALF_DIV cycles.
  - MOSI changes only at the start of the high phase.
  - The DAC latches on the SCLK falling edge.
  - Frame length FRAME = 48*HALF_DIV cycles of CS low; SCLK ends high.
- GAP: CS high, SCLK high, MOSI 0 for exactly CS_GAP cycles.
- RESP frame:
  - Same timing as CMD; MOSI word = 24'h000000 (NOP).
  - MISO is sampled in the clk cycle in which SCLK drives its falling edge and shifted into a 24-bit register, MSB first.
- DONE (the cycle CS returns high):
  - rd_valid=1 for one cycle; rd_data = shift[15:0].
  - rd_err = (shift[19:16] != latched addr).
  - Next cycle: bus_req=0, busy=0, state IDLE.
- Latency with bus_gnt already high and rd_req accepted at cycle 0: rd_valid at cycle 2 + 2*FRAME + CS_GAP (394 with defaults).
- bus_gnt:
  - Sampled only in REQ.
  - Once granted, the transaction runs to completion regardless of bus_gnt; the mux must not revoke the grant while bus_req=1.
- rd_req while busy, including in the DONE cycle, is ignored; there is no queue.
- Every 4-bit address, including unimplemented ones, is issued unchanged; a floating SDO (all ones) yields rd_err=1 unless addr=4'hF.

Test Plan:
- Basic read: DAC model loaded with DAC0 (addr 8) = 16'hABCD, bus_gnt tied 1, rd_req at cycle 0 with rd_addr=8 -> MOSI frames 24'h880000 then 24'h000000; rd_valid only at cycle 394; rd_data=16'hABCD; rd_err=0; busy low at cycle 395.
- Timing check: SCLK period 8 clk, 24 falling edges per frame, CS low 192 cycles per frame, gap exactly 8 cycles, SCLK high whenever CS is high.
- Grant delay: bus_gnt held low for 50 cycles after bus_req rises -> CS stays high throughout; rd_valid at cycle 444; bus_gnt dropped mid-CMD does not disturb the frame.
- Address mismatch: model echoes addr 4'h3 for a request to 4'h4 with data 16'h0102 -> rd_valid=1, rd_data=16'h0102, rd_err=1; MISO stuck at 1 on addr 4'h2 -> rd_data=16'hFFFF, rd_err=1.
- Busy rejection: second rd_req (addr 9) pulsed during CMD and again in the DONE cycle -> ignored; exactly one completion; bus_req low after DONE.
- Reset mid-RESP: rst_n low at cycle 300 -> CS=1, SCLK=1, MOSI=0, busy=0, rd_data=0 immediately; after release, a new read of addr 3 returns correct data with the nominal 394-cycle latency.
